// File: rtl/l2_cache_control_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : l2_types (package)
// Purpose  : Shared types for the L2 cache controller: FSM state encoding,
//            datapath select encodings and the way-index width.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
package l2_types;

  // Way index width; hit_way, plru_way and way_sel are all this wide.
  localparam int WAY_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITEBACK = 2'd1,
    ST_ALLOCATE  = 2'd2
  } state_t;

  // Source of the data written into the data array.
  typedef enum logic {
    SRC_WDATA = 1'b0,  // upstream write data
    SRC_PMEM  = 1'b1   // line returned from physical memory
  } data_src_t;

  // Address presented to physical memory.
  typedef enum logic {
    ADDR_REQ    = 1'b0,  // current request address
    ADDR_VICTIM = 1'b1   // victim tag + index (writeback)
  } addr_sel_t;

endpackage
`default_nettype wire

// File: rtl/l2_cache_control_sat_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : l2_sat_counter
// Purpose  : Up-counter that sticks at all-ones instead of wrapping.
// Ports    : clk, rst (sync, active-high), inc (count enable),
//            count (current value).
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module l2_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/l2_cache_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : l2_cache_control
// Purpose  : Control FSM for a set-associative write-back L2 cache.
//            Hits complete in the same cycle; misses optionally write back a
//            dirty victim, then allocate the line and replay as a hit.
// Ports    : clk, rst                         - clock, sync active-high reset
//            mem_read/mem_write/mem_resp      - upstream handshake
//            hit/hit_way                      - tag compare result
//            plru_way/victim_dirty            - replacement candidate
//            *_load, valid_in, dirty_in,
//            lru_load, way_sel, data_src,
//            addr_sel                         - datapath controls
//            pmem_read/pmem_write/pmem_resp   - memory handshake
//            hit_count/miss_count             - saturating perf counters
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module l2_cache_control
  import l2_types::*;
#(
  parameter int NUM_WAYS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic                hit,
  input  logic [WAY_W-1:0]    hit_way,
  input  logic [WAY_W-1:0]    plru_way,
  input  logic                victim_dirty,
  output logic [NUM_WAYS-1:0] valid_load,
  output logic [NUM_WAYS-1:0] dirty_load,
  output logic [NUM_WAYS-1:0] tag_load,
  output logic [NUM_WAYS-1:0] data_load,
  output logic                valid_in,
  output logic                dirty_in,
  output logic                lru_load,
  output logic [WAY_W-1:0]    way_sel,
  output logic                data_src,
  output logic                addr_sel,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);

  state_t           state;
  state_t           next_state;
  logic [WAY_W-1:0] victim;

  logic      req;
  logic      hit_ev;    // IDLE hit being answered this cycle
  logic      miss_ev;   // IDLE miss detected this cycle
  logic      wr_hit;    // write hit: update data + dirty of hit way
  logic      fill;      // memory line returned: load full entry of victim
  data_src_t data_src_e;
  addr_sel_t addr_sel_e;

  // A simultaneous read and write is handled as a write, so only mem_write
  // needs to be looked at once a request is known to be present.
  assign req = mem_read | mem_write;

  // ---------------------------------------------------------------------
  // State and victim registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      victim <= '0;
    end else begin
      state <= next_state;
      // Victim is frozen at miss detection so later PLRU movement cannot
      // redirect an in-flight writeback or fill.
      if (miss_ev) begin
        victim <= plru_way;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Next-state and output decode. Everything stays at its default while
  // rst is high, which also keeps the counters from counting.
  // ---------------------------------------------------------------------
  always_comb begin
    next_state = state;
    mem_resp   = 1'b0;
    lru_load   = 1'b0;
    way_sel    = '0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    valid_in   = 1'b0;
    dirty_in   = 1'b0;
    data_src_e = SRC_WDATA;
    addr_sel_e = ADDR_REQ;
    hit_ev     = 1'b0;
    miss_ev    = 1'b0;
    wr_hit     = 1'b0;
    fill       = 1'b0;

    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          // pmem_resp is deliberately not looked at here.
          if (req) begin
            if (hit) begin
              mem_resp = 1'b1;
              lru_load = 1'b1;
              way_sel  = hit_way;
              hit_ev   = 1'b1;
              if (mem_write) begin
                wr_hit     = 1'b1;
                dirty_in   = 1'b1;
                data_src_e = SRC_WDATA;
              end
            end else begin
              miss_ev    = 1'b1;
              next_state = victim_dirty ? ST_WRITEBACK : ST_ALLOCATE;
            end
          end
        end

        ST_WRITEBACK: begin
          pmem_write = 1'b1;
          addr_sel_e = ADDR_VICTIM;
          way_sel    = victim;
          if (pmem_resp) begin
            next_state = ST_ALLOCATE;
          end
        end

        ST_ALLOCATE: begin
          // Runs to completion even if the upstream request was dropped.
          pmem_read  = 1'b1;
          addr_sel_e = ADDR_REQ;
          way_sel    = victim;
          if (pmem_resp) begin
            fill       = 1'b1;
            valid_in   = 1'b1;
            dirty_in   = 1'b0;
            data_src_e = SRC_PMEM;
            next_state = ST_IDLE;
          end
        end

        default: begin
          next_state = ST_IDLE;
        end
      endcase
    end
  end

  assign data_src = data_src_e;
  assign addr_sel = addr_sel_e;

  // ---------------------------------------------------------------------
  // Per-way strobes: only the way on way_sel is ever written.
  // ---------------------------------------------------------------------
  for (genvar i = 0; i < NUM_WAYS; i++) begin : g_way_strobe
    logic sel;
    assign sel           = (way_sel == WAY_W'(i));
    assign data_load[i]  = (wr_hit | fill) & sel;
    assign dirty_load[i] = (wr_hit | fill) & sel;
    assign tag_load[i]   = fill & sel;
    assign valid_load[i] = fill & sel;
  end

  // ---------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------
  l2_sat_counter #(.WIDTH(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (hit_ev),
    .count (hit_count)
  );

  l2_sat_counter #(.WIDTH(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (miss_ev),
    .count (miss_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_l2_cache_control.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module   : tb_l2_cache_control
// Purpose  : Directed self-checking bench for l2_cache_control. Expected
//            control outputs are queued as each step is driven and popped
//            when the outputs are sampled mid-cycle; counters are checked
//            against a saturating reference every step.
// Revision : 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_l2_cache_control;

  localparam int CNT_W = 4;

  logic       clk;
  logic       rst;
  logic       mem_read, mem_write, mem_resp;
  logic       hit;
  logic [1:0] hit_way, plru_way;
  logic       victim_dirty;
  logic [3:0] valid_load, dirty_load, tag_load, data_load;
  logic       valid_in, dirty_in, lru_load;
  logic [1:0] way_sel;
  logic       data_src, addr_sel;
  logic       pmem_read, pmem_write, pmem_resp;
  logic [CNT_W-1:0] hit_count, miss_count;

  l2_cache_control #(.NUM_WAYS(4), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_resp     (mem_resp),
    .hit          (hit),
    .hit_way      (hit_way),
    .plru_way     (plru_way),
    .victim_dirty (victim_dirty),
    .valid_load   (valid_load),
    .dirty_load   (dirty_load),
    .tag_load     (tag_load),
    .data_load    (data_load),
    .valid_in     (valid_in),
    .dirty_in     (dirty_in),
    .lru_load     (lru_load),
    .way_sel      (way_sel),
    .data_src     (data_src),
    .addr_sel     (addr_sel),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic       mem_resp, lru_load, pmem_read, pmem_write;
    logic [3:0] ld_data, ld_dirty, ld_tag, ld_valid;
    logic       chk_way;   logic [1:0] way;
    logic       chk_addr;  logic       addr;
    logic       chk_vals;  logic       dirty_in, data_src;
    logic       chk_valid; logic       valid_in;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   exp_hits = 0;
  int   exp_misses = 0;
  bit   cnt_known = 1'b0;

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input logic [1:0] w);
    logic [3:0] v;
    v = 4'b0001;
    return v << w;
  endfunction

  function automatic int sat_inc(input int v);
    return (v == (1 << CNT_W) - 1) ? v : v + 1;
  endfunction

  function automatic exp_t e_idle(input string tag);
    exp_t e;
    e.tag = tag;
    e.mem_resp = 0; e.lru_load = 0; e.pmem_read = 0; e.pmem_write = 0;
    e.ld_data = 0; e.ld_dirty = 0; e.ld_tag = 0; e.ld_valid = 0;
    e.chk_way = 0; e.way = 0; e.chk_addr = 0; e.addr = 0;
    e.chk_vals = 0; e.dirty_in = 0; e.data_src = 0;
    e.chk_valid = 0; e.valid_in = 0;
    return e;
  endfunction

  // While rst is high every control output must be 0.
  function automatic exp_t e_rst(input string tag);
    exp_t e;
    e = e_idle(tag);
    e.chk_way = 1; e.chk_addr = 1; e.chk_vals = 1; e.chk_valid = 1;
    return e;
  endfunction

  function automatic exp_t e_hit(input string tag, input logic [1:0] w, input logic wr);
    exp_t e;
    e = e_idle(tag);
    e.mem_resp = 1; e.lru_load = 1; e.chk_way = 1; e.way = w;
    if (wr) begin
      e.ld_data = onehot(w); e.ld_dirty = onehot(w);
      e.chk_vals = 1; e.dirty_in = 1; e.data_src = 0;
    end
    return e;
  endfunction

  function automatic exp_t e_wb(input string tag, input logic [1:0] w);
    exp_t e;
    e = e_idle(tag);
    e.pmem_write = 1; e.chk_way = 1; e.way = w; e.chk_addr = 1; e.addr = 1;
    return e;
  endfunction

  function automatic exp_t e_alloc(input string tag, input logic [1:0] w, input logic resp);
    exp_t e;
    e = e_idle(tag);
    e.pmem_read = 1; e.chk_way = 1; e.way = w; e.chk_addr = 1; e.addr = 0;
    if (resp) begin
      e.ld_data = onehot(w); e.ld_dirty = onehot(w);
      e.ld_tag = onehot(w); e.ld_valid = onehot(w);
      e.chk_vals = 1; e.dirty_in = 0; e.data_src = 1;
      e.chk_valid = 1; e.valid_in = 1;
    end
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    e = sb.pop_front();
    cmp({e.tag, ".mem_resp"},   16'(mem_resp),   16'(e.mem_resp));
    cmp({e.tag, ".lru_load"},   16'(lru_load),   16'(e.lru_load));
    cmp({e.tag, ".pmem_read"},  16'(pmem_read),  16'(e.pmem_read));
    cmp({e.tag, ".pmem_write"}, 16'(pmem_write), 16'(e.pmem_write));
    cmp({e.tag, ".data_load"},  16'(data_load),  16'(e.ld_data));
    cmp({e.tag, ".dirty_load"}, 16'(dirty_load), 16'(e.ld_dirty));
    cmp({e.tag, ".tag_load"},   16'(tag_load),   16'(e.ld_tag));
    cmp({e.tag, ".valid_load"}, 16'(valid_load), 16'(e.ld_valid));
    if (e.chk_way)   cmp({e.tag, ".way_sel"},  16'(way_sel),  16'(e.way));
    if (e.chk_addr)  cmp({e.tag, ".addr_sel"}, 16'(addr_sel), 16'(e.addr));
    if (e.chk_vals) begin
      cmp({e.tag, ".dirty_in"}, 16'(dirty_in), 16'(e.dirty_in));
      cmp({e.tag, ".data_src"}, 16'(data_src), 16'(e.data_src));
    end
    if (e.chk_valid) cmp({e.tag, ".valid_in"}, 16'(valid_in), 16'(e.valid_in));
    if (cnt_known) begin
      cmp({e.tag, ".hit_count"},  16'(hit_count),  16'(exp_hits));
      cmp({e.tag, ".miss_count"}, 16'(miss_count), 16'(exp_misses));
    end
  endtask

  // Inputs are already driven; sample at the falling edge, then advance
  // just past the next rising edge.
  task automatic step(input exp_t e);
    sb.push_back(e);
    @(negedge clk);
    check_out();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; mem_read = 1; mem_write = 0; hit = 1; hit_way = 2;
    plru_way = 0; victim_dirty = 0; pmem_resp = 0;

    // Reset with a hit present: outputs must stay quiet.
    step(e_rst("rst_c0"));
    cnt_known = 1'b1;
    step(e_rst("rst_c1"));
    rst = 0; mem_read = 0; hit = 0;

    // pmem_resp in IDLE has no effect.
    pmem_resp = 1;
    step(e_idle("idle_pmem_resp"));
    pmem_resp = 0;
    step(e_idle("idle_quiet"));

    // Read hit, write hit, read+write treated as write.
    mem_read = 1; hit = 1; hit_way = 2;
    step(e_hit("rd_hit", 2, 0));  exp_hits = sat_inc(exp_hits);
    mem_read = 0; mem_write = 1; hit_way = 1;
    step(e_hit("wr_hit", 1, 1));  exp_hits = sat_inc(exp_hits);
    mem_read = 1; mem_write = 1; hit_way = 3;
    step(e_hit("rw_hit", 3, 1));  exp_hits = sat_inc(exp_hits);

    // Clean miss to way 3, fill after 5 ALLOCATE cycles, then replay hit.
    mem_write = 0; mem_read = 1; hit = 0; plru_way = 3; victim_dirty = 0;
    step(e_idle("clean_miss_det")); exp_misses = sat_inc(exp_misses);
    for (int i = 0; i < 4; i++) begin
      plru_way = 2'(i);
      step(e_alloc("clean_alloc_wait", 3, 0));
    end
    pmem_resp = 1;
    step(e_alloc("clean_fill", 3, 1));
    pmem_resp = 0; hit = 1; hit_way = 3;
    step(e_hit("clean_rehit", 3, 0)); exp_hits = sat_inc(exp_hits);

    // Dirty miss on way 0; PLRU moves to 2 mid-miss; request dropped in ALLOCATE.
    hit = 0; plru_way = 0; victim_dirty = 1;
    step(e_idle("dirty_miss_det")); exp_misses = sat_inc(exp_misses);
    plru_way = 2; victim_dirty = 0;
    step(e_wb("dirty_wb_c1", 0));
    step(e_wb("dirty_wb_c2", 0));
    pmem_resp = 1;
    step(e_wb("dirty_wb_resp", 0));
    pmem_resp = 0; mem_read = 0;
    step(e_alloc("dirty_alloc", 0, 0));
    pmem_resp = 1;
    step(e_alloc("dirty_fill", 0, 1));
    pmem_resp = 0;
    step(e_idle("dirty_done"));

    // Reset during the third ALLOCATE cycle abandons the fill.
    mem_read = 1; hit = 0; plru_way = 1; victim_dirty = 0;
    step(e_idle("rst_miss_det")); exp_misses = sat_inc(exp_misses);
    step(e_alloc("rst_alloc_c1", 1, 0));
    step(e_alloc("rst_alloc_c2", 1, 0));
    rst = 1; pmem_resp = 1;
    step(e_rst("rst_in_alloc"));
    exp_hits = 0; exp_misses = 0;
    rst = 0; pmem_resp = 0; mem_read = 0;
    step(e_idle("post_rst_idle"));

    // 17 hits on a 4-bit counter: saturates at 15.
    mem_read = 1; hit = 1; hit_way = 0;
    for (int i = 0; i < 17; i++) begin
      step(e_hit("sat_hit", 0, 0));
      exp_hits = sat_inc(exp_hits);
    end
    mem_read = 0; hit = 0;
    step(e_idle("sat_done"));
    cmp("sat_final_hit_count", 16'(hit_count), 16'd15);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
